// File: rtl/pipe_pkg.sv
// Shared definitions for the IF/ID pipeline register: FSM state encodings
// and the default data width / bubble instruction word.
package pipe_pkg;

  localparam int          PIPE_WIDTH    = 32;
  localparam logic [31:0] PIPE_NOP_INST = 32'h0000_0000;  // sll $0,$0,0

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2
  } pipe_state_e;

endpackage : pipe_pkg

// File: rtl/sat_counter.sv
// Unsigned event counter with enable that sticks at all-ones instead of
// wrapping; cleared asynchronously by an active-low reset.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule : sat_counter

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: captures PC+4 and the fetched instruction each
// cycle, with stall (hold), flush (bubble) and fetch-side event counters.
module if_id_pipe_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH    = PIPE_WIDTH,
  parameter logic [WIDTH-1:0] NOP_INST = WIDTH'(PIPE_NOP_INST),
  parameter int               CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hazard,
  input  logic             flush,
  input  logic [WIDTH-1:0] PCIn,
  input  logic [WIDTH-1:0] instIn,
  output logic [WIDTH-1:0] PCOut,
  output logic [WIDTH-1:0] instOut,
  output logic             validOut,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cntFetched,
  output logic [CNT_W-1:0] cntFlushed,
  output logic [CNT_W-1:0] cntStalled
);

  pipe_state_e      state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] inst_q, inst_d;
  logic             valid_q, valid_d;
  logic             state_legal;
  logic             inc_fetched, inc_flushed, inc_stalled;

  always_comb begin
    case (state_q)
      ST_EMPTY, ST_RUN, ST_HOLD: state_legal = 1'b1;
      default:                   state_legal = 1'b0;
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the if/else chain can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    valid_d     = valid_q;
    inc_fetched = 1'b0;
    inc_flushed = 1'b0;
    inc_stalled = 1'b0;

    if (flush) begin
      pc_d        = '0;
      inst_d      = NOP_INST;
      valid_d     = 1'b0;
      state_d     = ST_EMPTY;
      // Count only when something real was squashed: the held instruction
      // or the one that would have been captured this edge.
      inc_flushed = valid_q | ~hazard;
    end else if (!state_legal) begin
      pc_d    = '0;
      inst_d  = NOP_INST;
      valid_d = 1'b0;
      state_d = ST_EMPTY;
    end else if (hazard) begin
      inc_stalled = 1'b1;
      state_d     = (state_q == ST_EMPTY) ? ST_EMPTY : ST_HOLD;
    end else begin
      pc_d        = PCIn;
      inst_d      = instIn;
      valid_d     = 1'b1;
      state_d     = ST_RUN;
      inc_fetched = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      pc_q    <= '0;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign PCOut    = pc_q;
  assign instOut  = inst_q;
  assign validOut = valid_q;
  assign state    = state_q;

  sat_counter #(.W(CNT_W)) u_cnt_fetched (
    .clk     (clk),
    .rst_n   (reset),
    .en_i    (inc_fetched),
    .count_o (cntFetched)
  );

  sat_counter #(.W(CNT_W)) u_cnt_flushed (
    .clk     (clk),
    .rst_n   (reset),
    .en_i    (inc_flushed),
    .count_o (cntFlushed)
  );

  sat_counter #(.W(CNT_W)) u_cnt_stalled (
    .clk     (clk),
    .rst_n   (reset),
    .en_i    (inc_stalled),
    .count_o (cntStalled)
  );

endmodule : if_id_pipe_reg

// File: tb/tb_if_id_pipe_reg.sv
// Scoreboard bench for if_id_pipe_reg: a 32-bit-counter instance and a
// 4-bit-counter instance share stimulus; expectations queue per cycle.
module tb_if_id_pipe_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        hazard, flush;
  logic [31:0] PCIn, instIn;
  logic [31:0] PCOut, instOut;
  logic        validOut;
  logic [1:0]  state;
  logic [31:0] cntFetched, cntFlushed, cntStalled;

  logic [31:0] PCOut4, instOut4;
  logic        validOut4;
  logic [1:0]  state4;
  logic [3:0]  cntFetched4, cntFlushed4, cntStalled4;

  always #5 clk = ~clk;

  if_id_pipe_reg #(.WIDTH(32), .NOP_INST(32'h0), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .hazard(hazard), .flush(flush),
    .PCIn(PCIn), .instIn(instIn), .PCOut(PCOut), .instOut(instOut),
    .validOut(validOut), .state(state), .cntFetched(cntFetched),
    .cntFlushed(cntFlushed), .cntStalled(cntStalled)
  );

  if_id_pipe_reg #(.WIDTH(32), .NOP_INST(32'h0), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .hazard(hazard), .flush(flush),
    .PCIn(PCIn), .instIn(instIn), .PCOut(PCOut4), .instOut(instOut4),
    .validOut(validOut4), .state(state4), .cntFetched(cntFetched4),
    .cntFlushed(cntFlushed4), .cntStalled(cntStalled4)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic [1:0]  st;
    logic [31:0] fetched, flushed, stalled;
    logic [3:0]  fetched4, flushed4, stalled4;
  } exp_t;

  exp_t  sb_q[$];
  exp_t  m;
  int    n_checks = 0;
  int    n_bad    = 0;
  string phase    = "init";

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s [%s] got=%0h expected=%0h", tag, phase, got, exp);
    end
  endtask

  function automatic logic [31:0] sat32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [3:0] sat4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  task automatic model_reset();
    m.pc = '0; m.inst = '0; m.valid = 1'b0; m.st = 2'd0;
    m.fetched = '0; m.flushed = '0; m.stalled = '0;
    m.fetched4 = '0; m.flushed4 = '0; m.stalled4 = '0;
  endtask

  // Expected register contents after the coming edge, from the inputs now driven.
  task automatic model_step();
    if (!reset) begin
      model_reset();
    end else if (flush) begin
      if (m.valid || !hazard) begin
        m.flushed  = sat32(m.flushed);
        m.flushed4 = sat4(m.flushed4);
      end
      m.pc = '0; m.inst = '0; m.valid = 1'b0; m.st = 2'd0;
    end else if (hazard) begin
      m.stalled  = sat32(m.stalled);
      m.stalled4 = sat4(m.stalled4);
      if (m.st != 2'd0) m.st = 2'd2;
    end else begin
      m.pc = PCIn; m.inst = instIn; m.valid = 1'b1; m.st = 2'd1;
      m.fetched  = sat32(m.fetched);
      m.fetched4 = sat4(m.fetched4);
    end
  endtask

  task automatic compare_all(input exp_t e);
    check("PCOut",       64'(PCOut),       64'(e.pc));
    check("instOut",     64'(instOut),     64'(e.inst));
    check("validOut",    64'(validOut),    64'(e.valid));
    check("state",       64'(state),       64'(e.st));
    check("cntFetched",  64'(cntFetched),  64'(e.fetched));
    check("cntFlushed",  64'(cntFlushed),  64'(e.flushed));
    check("cntStalled",  64'(cntStalled),  64'(e.stalled));
    check("cntFetched4", 64'(cntFetched4), 64'(e.fetched4));
    check("cntFlushed4", 64'(cntFlushed4), 64'(e.flushed4));
    check("cntStalled4", 64'(cntStalled4), 64'(e.stalled4));
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic do_cycle(input logic h, input logic f,
                          input logic [31:0] pc, input logic [31:0] inst);
    exp_t e;
    hazard = h; flush = f; PCIn = pc; instIn = inst;
    model_step();
    sb_q.push_back(m);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    compare_all(e);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; hazard = 1'b0; flush = 1'b0;
    PCIn = 32'd4; instIn = 32'h2002_0005;
    model_reset();
    @(negedge clk);

    phase = "reset";
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b0, 32'd4, 32'h2002_0005);

    reset = 1'b1;
    phase = "normal";
    do_cycle(1'b0, 1'b0, 32'd4,  32'hAAAA_0001);
    do_cycle(1'b0, 1'b0, 32'd8,  32'hBBBB_0002);
    do_cycle(1'b0, 1'b0, 32'd12, 32'hCCCC_0003);
    check("fetched_after_3", 64'(cntFetched), 64'd3);

    phase = "stall";
    do_cycle(1'b0, 1'b0, 32'd8,  32'hDDDD_0004);
    do_cycle(1'b1, 1'b0, 32'd12, 32'h1111_0005);
    do_cycle(1'b1, 1'b0, 32'd16, 32'h2222_0006);
    check("held_pc",      64'(PCOut),      64'd8);
    check("stalled_two",  64'(cntStalled), 64'd2);
    do_cycle(1'b0, 1'b0, 32'd20, 32'h3333_0007);

    phase = "flush";
    do_cycle(1'b0, 1'b1, 32'd24, 32'h4444_0008);
    check("flushed_one", 64'(cntFlushed), 64'd1);
    do_cycle(1'b0, 1'b0, 32'd24, 32'h4444_0008);

    phase = "flush_hazard_empty";
    do_cycle(1'b0, 1'b1, 32'd28, 32'h5555_0009);
    do_cycle(1'b1, 1'b1, 32'd28, 32'h5555_0009);

    phase = "flush_hazard_hold";
    do_cycle(1'b0, 1'b0, 32'd28, 32'h5555_0009);
    do_cycle(1'b1, 1'b0, 32'd32, 32'h6666_000A);
    do_cycle(1'b1, 1'b1, 32'd32, 32'h6666_000A);

    phase = "async_reset";
    do_cycle(1'b0, 1'b0, 32'd36, 32'h7777_000B);
    do_cycle(1'b1, 1'b0, 32'd40, 32'h8888_000C);
    #2 reset = 1'b0;
    #1;
    check("arst_PCOut",      64'(PCOut),      64'd0);
    check("arst_instOut",    64'(instOut),    64'd0);
    check("arst_validOut",   64'(validOut),   64'd0);
    check("arst_state",      64'(state),      64'd0);
    check("arst_cntFetched", 64'(cntFetched), 64'd0);
    check("arst_cntStalled", 64'(cntStalled), 64'd0);
    model_reset();
    @(negedge clk);
    do_cycle(1'b1, 1'b0, 32'd40, 32'h8888_000C);
    reset = 1'b1;

    phase = "saturate";
    for (int i = 0; i < 20; i++) do_cycle(1'b0, 1'b0, 32'(4 * i), $urandom);
    check("sat4_fetched", 64'(cntFetched4), 64'hF);
    check("fetched_20",   64'(cntFetched),  64'd20);

    phase = "random";
    for (int i = 0; i < 40; i++)
      do_cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0),
               $urandom, $urandom);

    if (sb_q.size() != 0) check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule : tb_if_id_pipe_reg
